// File: rtl/axi_pwm_pkg.sv
// Shared constants, FSM state types and byte-lane merge helper for the AXI4-Lite PWM slave.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package axi_pwm_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_PERIOD = 3'd1;
  localparam logic [2:0] REG_DUTY0  = 3'd2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/pwm_core.sv
// Shared 0..PERIOD counter with per-channel duty comparators; PWM_SHADOW_EN makes PERIOD/DUTY take effect only at wrap.
// Latency: pwm_out is registered one cycle after the counter value it reflects.
// Backpressure: none; free-running.
module pwm_core #(
  parameter int C_NUM_CH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [C_NUM_CH-1:0]      ctrl,
  input  logic [31:0]              period,
  input  logic [C_NUM_CH-1:0][31:0] duty,
  output logic [C_NUM_CH-1:0]      pwm_out
);

  logic [31:0]               cnt;
  logic [31:0]               period_a;
  logic [C_NUM_CH-1:0][31:0] duty_a;
  logic                      wrap;

  assign wrap = (period_a != '0) && (cnt >= period_a);

`ifdef PWM_SHADOW_EN
  // Active copies follow the programmed values only at wrap, or freely while the counter is parked.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_a <= '0;
      duty_a   <= '0;
    end else if (wrap || (period_a == '0)) begin
      period_a <= period;
      duty_a   <= duty;
    end
  end
`else
  assign period_a = period;
  assign duty_a   = duty;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      pwm_out <= '0;
    end else begin
      if ((period_a == '0) || wrap) cnt <= '0;
      else                          cnt <= cnt + 32'd1;
      for (int i = 0; i < C_NUM_CH; i++)
        pwm_out[i] <= ctrl[i] && (cnt < duty_a[i]);
    end
  end

endmodule

// File: rtl/axi_lite_pwm_slave.sv
// AXI4-Lite register slave (CTRL, PERIOD, DUTYn) feeding pwm_core; define PWM_SHADOW_EN for wrap-aligned updates.
// Latency: BVALID 1 cycle after the later of the AW/W handshakes; RVALID 1 cycle after the AR handshake.
// Backpressure: one write and one read in flight; READY stays low until BREADY/RREADY retire the response.
module axi_lite_pwm_slave
  import axi_pwm_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_NUM_CH           = 6
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [C_NUM_CH-1:0]           pwm_out
);

  w_state_t w_state, w_state_d;
  r_state_t r_state, r_state_d;

  logic                      aw_latched, w_latched;
  logic [2:0]                aw_idx_q;
  logic [31:0]               wdata_q;
  logic [3:0]                wstrb_q;
  logic [31:0]               rdata_q;
  logic [C_NUM_CH-1:0]       ctrl_r;
  logic [31:0]               period_r;
  logic [C_NUM_CH-1:0][31:0] duty_r;

  logic        aw_hs, w_hs, ar_hs, wr_en;
  logic [2:0]  wr_idx;
  logic [31:0] wr_data, wr_merged;
  logic [3:0]  wr_strb;
  logic        unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic [31:0] reg_read(input logic [2:0] idx);
    logic [31:0] v;
    v = '0;
    if (idx == REG_CTRL)        v[C_NUM_CH-1:0] = ctrl_r;
    else if (idx == REG_PERIOD) v = period_r;
    for (int i = 0; i < C_NUM_CH; i++)
      if (idx == 3'(REG_DUTY0 + i)) v = duty_r[i];
    return v;
  endfunction

  // READY is held low during reset so nothing is accepted while the block is being cleared.
  assign S_AXI_AWREADY = !ARESET && (w_state == W_IDLE) && !aw_latched;
  assign S_AXI_WREADY  = !ARESET && (w_state == W_IDLE) && !w_latched;
  assign S_AXI_ARREADY = !ARESET && (r_state == R_IDLE);
  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  assign S_AXI_BVALID = (w_state == W_RESP);
  assign S_AXI_BRESP  = RESP_OKAY;
  assign S_AXI_RVALID = (r_state == R_DATA);
  assign S_AXI_RRESP  = RESP_OKAY;
  assign S_AXI_RDATA  = rdata_q;

  // A channel arriving this cycle bypasses its latch so the write lands on the later handshake edge.
  assign wr_idx    = aw_latched ? aw_idx_q : S_AXI_AWADDR[4:2];
  assign wr_data   = w_latched  ? wdata_q  : S_AXI_WDATA;
  assign wr_strb   = w_latched  ? wstrb_q  : S_AXI_WSTRB;
  assign wr_merged = apply_wstrb(reg_read(wr_idx), wr_data, wr_strb);

  always_comb begin
    w_state_d = w_state;
    wr_en     = 1'b0;
    case (w_state)
      W_IDLE: if ((aw_latched || aw_hs) && (w_latched || w_hs)) begin
        wr_en     = 1'b1;
        w_state_d = W_RESP;
      end
      W_RESP: if (S_AXI_BREADY) w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state;
    case (r_state)
      R_IDLE: if (ar_hs) r_state_d = R_DATA;
      R_DATA: if (S_AXI_RREADY) r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state    <= W_IDLE;
      r_state    <= R_IDLE;
      aw_latched <= 1'b0;
      w_latched  <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      ctrl_r     <= '0;
      period_r   <= '0;
      duty_r     <= '0;
    end else begin
      w_state <= w_state_d;
      r_state <= r_state_d;
      if ((w_state == W_RESP) && S_AXI_BREADY) begin
        aw_latched <= 1'b0;
        w_latched  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_latched <= 1'b1;
          aw_idx_q   <= S_AXI_AWADDR[4:2];
        end
        if (w_hs) begin
          w_latched <= 1'b1;
          wdata_q   <= S_AXI_WDATA;
          wstrb_q   <= S_AXI_WSTRB;
        end
      end
      // Sampled before this edge's write, so a colliding read returns the old value.
      if (ar_hs) rdata_q <= reg_read(S_AXI_ARADDR[4:2]);
      if (wr_en) begin
        if (wr_idx == REG_CTRL)   ctrl_r   <= wr_merged[C_NUM_CH-1:0];
        if (wr_idx == REG_PERIOD) period_r <= wr_merged;
        for (int i = 0; i < C_NUM_CH; i++)
          if (wr_idx == 3'(REG_DUTY0 + i)) duty_r[i] <= wr_merged;
      end
    end
  end

  pwm_core #(.C_NUM_CH(C_NUM_CH)) u_pwm_core (
    .clk     (ACLK),
    .rst     (ARESET),
    .ctrl    (ctrl_r),
    .period  (period_r),
    .duty    (duty_r),
    .pwm_out (pwm_out)
  );

endmodule

// File: tb/tb_axi_lite_pwm_slave.sv
// Directed bench for axi_lite_pwm_slave: register access, handshake ordering, backpressure, reset and PWM duty patterns.
// The wrap-aligned duty update is exercised only when PWM_SHADOW_EN is defined.
module tb_axi_lite_pwm_slave;
  import axi_pwm_pkg::*;

  logic        tb_ACLK = 1'b0;
  logic        areset;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [5:0]  pwm_out;
  int          checks = 0;
  int          errors = 0;

  always #5 tb_ACLK = ~tb_ACLK;

  axi_lite_pwm_slave dut (
    .ACLK(tb_ACLK), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .pwm_out(pwm_out)
  );

`ifdef PWM_SHADOW_EN
  int run_len = 0, last_run = 0, run_cnt = 0;
  always @(negedge tb_ACLK) begin
    if (pwm_out[0]) run_len++;
    else if (run_len != 0) begin
      last_run = run_len;
      run_cnt++;
      run_len = 0;
    end
  end
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge tb_ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    bit aw_done, w_done, b_done;
    aw_done = 0; w_done = 0; b_done = 0;
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1; bready = 1;
    for (int n = 0; n < 20 && !b_done; n++) begin
      @(negedge tb_ACLK);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      if (bvalid) begin
        b_done = 1;
        check("bresp", {30'd0, bresp}, {30'd0, RESP_OKAY});
      end
      @(posedge tb_ACLK); #1;
      if (aw_done) awvalid = 0;
      if (w_done) wvalid = 0;
    end
    bready = 0; awvalid = 0; wvalid = 0;
    if (!b_done) check("wr_timeout", 32'(b_done), 32'd1);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
    bit ar_done, r_done;
    ar_done = 0; r_done = 0; d = 'x; r = 'x;
    araddr = a; arvalid = 1; rready = 1;
    for (int n = 0; n < 20 && !r_done; n++) begin
      @(negedge tb_ACLK);
      if (arvalid && arready) ar_done = 1;
      if (rvalid) begin
        d = rdata; r = rresp; r_done = 1;
      end
      @(posedge tb_ACLK); #1;
      if (ar_done) arvalid = 0;
    end
    rready = 0; arvalid = 0;
    if (!r_done) check("rd_timeout", 32'(r_done), 32'd1);
  endtask

  task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    check(tag, d, exp);
    check({tag, "_rresp"}, {30'd0, r}, {30'd0, RESP_OKAY});
  endtask

  task automatic count_pwm(input int n, output int hi, output int oth);
    hi = 0; oth = 0;
    repeat (n) begin
      @(negedge tb_ACLK);
      if (pwm_out[0]) hi++;
      if (pwm_out[5:1] != 5'd0) oth++;
    end
    @(posedge tb_ACLK); #1;
  endtask

  task automatic pwm_step(input string tag, input logic [4:0] a, input logic [31:0] d,
                          input int exp_hi, input int exp_oth);
    int hi, oth;
    axi_write(a, d, 4'hF);
    cycles(15);
    count_pwm(20, hi, oth);
    check({tag, "_ch0_high"}, 32'(hi), 32'(exp_hi));
    check({tag, "_ch1to5_high"}, 32'(oth), 32'(exp_oth));
  endtask

  initial begin
    areset = 1; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    wdata = '0; wstrb = '0;

    // Reset state
    repeat (3) @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    @(posedge tb_ACLK); #1;
    areset = 0;
    @(negedge tb_ACLK);
    check("idle_awready", 32'(awready), 32'd1);
    check("idle_arready", 32'(arready), 32'd1);
    @(posedge tb_ACLK); #1;

    // Register write/readback
    axi_write(5'h00, 32'h0101FFFF, 4'hF);
    rd_check("ctrl", 5'h00, 32'h0000003F);
    axi_write(5'h04, 32'habcd0001, 4'hF);
    axi_write(5'h08, 32'hdead0011, 4'hF);
    axi_write(5'h0C, 32'hbeef0011, 4'hF);
    rd_check("period", 5'h04, 32'habcd0001);
    rd_check("duty0", 5'h08, 32'hdead0011);
    rd_check("duty1", 5'h0C, 32'hbeef0011);
    rd_check("duty1_lowbits_ignored", 5'h0E, 32'hbeef0011);

    // Read and write to the same register in the same cycle
    awaddr = 5'h04; wdata = 32'h11112222; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 5'h04; arvalid = 1; bready = 1; rready = 1;
    @(negedge tb_ACLK);
    check("rw_all_ready", {29'd0, awready, wready, arready}, 32'd7);
    @(posedge tb_ACLK); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge tb_ACLK);
    check("rw_bvalid", 32'(bvalid), 32'd1);
    check("rw_rvalid", 32'(rvalid), 32'd1);
    check("rw_old_value", rdata, 32'habcd0001);
    @(posedge tb_ACLK); #1;
    bready = 0; rready = 0;
    rd_check("rw_new_value", 5'h04, 32'h11112222);

    // W three cycles ahead of AW, partial strobe, BREADY held low
    wdata = 32'h12345678; wstrb = 4'b0011; wvalid = 1;
    @(negedge tb_ACLK);
    check("wfirst_wready", 32'(wready), 32'd1);
    @(posedge tb_ACLK); #1;
    wvalid = 0;
    @(negedge tb_ACLK);
    check("wfirst_wready_latched", 32'(wready), 32'd0);
    check("wfirst_no_bvalid", 32'(bvalid), 32'd0);
    @(posedge tb_ACLK); #1;
    @(posedge tb_ACLK); #1;
    awaddr = 5'h0C; awvalid = 1;
    @(negedge tb_ACLK);
    check("wfirst_awready", 32'(awready), 32'd1);
    check("wfirst_bvalid_pre_aw", 32'(bvalid), 32'd0);
    @(posedge tb_ACLK); #1;
    awvalid = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge tb_ACLK);
      check("bhold_bvalid", 32'(bvalid), 32'd1);
      check("bhold_awready", 32'(awready), 32'd0);
      check("bhold_wready", 32'(wready), 32'd0);
      @(posedge tb_ACLK); #1;
    end
    bready = 1;
    @(negedge tb_ACLK);
    check("bhold_bresp", {30'd0, bresp}, {30'd0, RESP_OKAY});
    @(posedge tb_ACLK); #1;
    bready = 0;
    @(negedge tb_ACLK);
    check("bdone_bvalid", 32'(bvalid), 32'd0);
    check("bdone_awready", 32'(awready), 32'd1);
    check("bdone_wready", 32'(wready), 32'd1);
    @(posedge tb_ACLK); #1;
    rd_check("duty1_strobed", 5'h0C, 32'hbeef5678);

    // Reset in the middle of a read
    araddr = 5'h04; arvalid = 1; rready = 0;
    @(negedge tb_ACLK);
    check("mr_arready", 32'(arready), 32'd1);
    @(posedge tb_ACLK); #1;
    arvalid = 0;
    @(negedge tb_ACLK);
    check("mr_rvalid_before", 32'(rvalid), 32'd1);
    check("mr_rdata_before", rdata, 32'h11112222);
    @(posedge tb_ACLK); #1;
    areset = 1;
    @(posedge tb_ACLK); #1;
    @(negedge tb_ACLK);
    check("mr_rvalid_after", 32'(rvalid), 32'd0);
    check("mr_rdata_after", rdata, 32'd0);
    check("mr_arready_in_rst", 32'(arready), 32'd0);
    @(posedge tb_ACLK); #1;
    areset = 0;
    rd_check("mr_ctrl", 5'h00, 32'd0);
    rd_check("mr_period", 5'h04, 32'd0);
    rd_check("mr_duty0", 5'h08, 32'd0);
    rd_check("mr_duty1", 5'h0C, 32'd0);

    // PWM: PERIOD=9 gives a 10-cycle frame; 20-cycle window covers two frames
    axi_write(5'h04, 32'd9, 4'hF);
    axi_write(5'h0C, 32'd20, 4'hF);
    axi_write(5'h08, 32'd3, 4'hF);
    pwm_step("pwm_d3", 5'h00, 32'h1, 6, 0);
    pwm_step("pwm_d0", 5'h08, 32'd0, 0, 0);
    pwm_step("pwm_d9", 5'h08, 32'd9, 18, 0);
    pwm_step("pwm_d10", 5'h08, 32'd10, 20, 0);
    pwm_step("pwm_d20", 5'h08, 32'd20, 20, 0);
    pwm_step("pwm_ctrl0", 5'h00, 32'h0, 0, 0);
    pwm_step("pwm_ctrl3", 5'h00, 32'h3, 20, 20);
    axi_write(5'h00, 32'h1, 4'hF);
    axi_write(5'h08, 32'd1, 4'hF);
    pwm_step("pwm_p0_d1", 5'h04, 32'd0, 20, 0);
    pwm_step("pwm_p0_d0", 5'h08, 32'd0, 0, 0);

`ifdef PWM_SHADOW_EN
    begin
      bit found;
      logic prev;
      int r0;
      axi_write(5'h04, 32'd9, 4'hF);
      axi_write(5'h08, 32'd3, 4'hF);
      cycles(15);
      found = 0; prev = 1'b1;
      for (int n = 0; n < 40 && !found; n++) begin
        @(negedge tb_ACLK);
        if (pwm_out[0] && !prev) found = 1;
        prev = pwm_out[0];
      end
      check("shadow_rise_seen", 32'(found), 32'd1);
      @(posedge tb_ACLK); #1;
      r0 = run_cnt;
      axi_write(5'h08, 32'd7, 4'hF);
      for (int n = 0; n < 40 && run_cnt < r0 + 1; n++) begin
        @(negedge tb_ACLK); #1;
      end
      check("shadow_old_run", 32'(last_run), 32'd3);
      for (int n = 0; n < 40 && run_cnt < r0 + 2; n++) begin
        @(negedge tb_ACLK); #1;
      end
      check("shadow_new_run", 32'(last_run), 32'd7);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
